toggle_period_meter: RTL and testbench

Measures the spacing, in `clk` cycles, between successive transitions of a toggling input. It is the receive-side counterpart of the counter/toggle generator. Each completed interval is presented on a valid/ready output so downstream logic can check or report a divided clock's rate. Sticky flags report lost measurements and a stalled input.

---
 rtl/toggle_period_meter.sv | 130 +++++++++++++
 tb/tb_toggle_period_meter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/toggle_period_meter.sv
// Measures clk cycles between successive edges of toggle_in; optional two-flop input synchroniser under TOGGLE_SYNC_EN.
// Latency: period_valid one cycle after the closing edge is sampled (three with TOGGLE_SYNC_EN).
// Backpressure: one-deep output; a capture arriving while an unconsumed period is held is dropped and flagged in overrun.
module toggle_period_meter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic             toggle_in,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    input  logic             period_ready,
    output logic             overrun,
    output logic             timeout
);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(TIMEOUT);

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic             tog_s;
    logic             tog_d;
    logic             edge_det;
    logic             capture;
    logic             expire;
    logic             transfer;

`ifdef TOGGLE_SYNC_EN
    logic sync_q1;
    logic sync_q2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= toggle_in;
            sync_q2 <= sync_q1;
        end
    end

    assign tog_s = sync_q2;
`else
    assign tog_s = toggle_in;
`endif

    // History tracks the input in every state so a static level never reads as an edge.
    always_ff @(posedge clk) begin
        if (rst) tog_d <= 1'b0;
        else     tog_d <= tog_s;
    end

    assign edge_det = tog_s ^ tog_d;

    always_comb begin
        capture  = 1'b0;
        expire   = 1'b0;
        transfer = period_valid && period_ready;
        if (enable && state == MEASURE) begin
            capture = edge_det;
            expire  = !edge_det && (cnt == CNT_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (!enable) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= ARM;
                    cnt   <= '0;
                end
                ARM: begin
                    if (edge_det) begin
                        state <= MEASURE;
                        cnt   <= WIDTH'(1);
                    end
                end
                MEASURE: begin
                    if (edge_det) begin
                        cnt <= WIDTH'(1);
                    end else if (cnt == CNT_MAX) begin
                        state <= ARM;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + WIDTH'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Setting events are evaluated after clear so a coincident set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            period       <= '0;
            period_valid <= 1'b0;
            overrun      <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            if (capture && (!period_valid || period_ready)) begin
                period       <= cnt;
                period_valid <= 1'b1;
            end else if (transfer) begin
                period_valid <= 1'b0;
            end
            if (clear) begin
                overrun <= 1'b0;
                timeout <= 1'b0;
            end
            if (capture && period_valid && !period_ready) overrun <= 1'b1;
            if (expire) timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_toggle_period_meter.sv
module tb_toggle_period_meter;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         enable;
    logic         clear;
    logic         toggle_in;
    logic [W-1:0] period;
    logic         period_valid;
    logic         period_ready;
    logic         overrun;
    logic         timeout;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] sb[$];

    toggle_period_meter #(.WIDTH(W), .TIMEOUT(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .clear        (clear),
        .toggle_in    (toggle_in),
        .period       (period),
        .period_valid (period_valid),
        .period_ready (period_ready),
        .overrun      (overrun),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every accepted transfer must match the oldest expected period.
    always @(negedge clk) begin
        if (!rst && period_valid && period_ready) begin
            logic [W-1:0] exp_p;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL transfer_unexpected period=%0d expected none", period);
            end else begin
                exp_p = sb.pop_front();
                if (period !== exp_p) begin
                    errors++;
                    $display("FAIL transfer_value period=%0d expected %0d", period, exp_p);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic flip();
        toggle_in = ~toggle_in;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(3);
        checks++; if (period !== '0)      begin errors++; $display("FAIL reset_period got=%0d exp=0", period); end
        checks++; if (period_valid !== 0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", period_valid); end
        checks++; if (overrun !== 0)      begin errors++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
        checks++; if (timeout !== 0)      begin errors++; $display("FAIL reset_timeout got=%0b exp=0", timeout); end
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic test_steady();
        enable = 1'b0; toggle_in = 1'b0; period_ready = 1'b1;
        cyc(4);
        enable = 1'b1;
        cyc(2);
        for (int i = 0; i < 6; i++) begin
            flip();
            if (i > 0) sb.push_back(W'(6));
            cyc(6);
        end
        checks++; if (overrun !== 0) begin errors++; $display("FAIL steady_overrun got=%0b exp=0", overrun); end
        checks++; if (timeout !== 0) begin errors++; $display("FAIL steady_timeout got=%0b exp=0", timeout); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL steady_pending got=%0d exp=0", sb.size()); end
        enable = 1'b0;
        cyc(2);
    endtask

    task automatic test_backpressure();
        enable = 1'b0; toggle_in = 1'b0; period_ready = 1'b0;
        cyc(4);
        enable = 1'b1;
        cyc(2);
        flip(); cyc(4);
        flip(); sb.push_back(W'(4)); cyc(4);
        flip(); cyc(3);
        checks++; if (overrun !== 1)      begin errors++; $display("FAIL bp_overrun got=%0b exp=1", overrun); end
        checks++; if (period !== W'(4))   begin errors++; $display("FAIL bp_period_held got=%0d exp=4", period); end
        checks++; if (period_valid !== 1) begin errors++; $display("FAIL bp_valid got=%0b exp=1", period_valid); end
        clear = 1'b1; cyc(1); clear = 1'b0;
        checks++; if (overrun !== 0) begin errors++; $display("FAIL bp_clear got=%0b exp=0", overrun); end
        enable = 1'b0; period_ready = 1'b1;
        cyc(3);
        checks++; if (sb.size() != 0)     begin errors++; $display("FAIL bp_pending got=%0d exp=0", sb.size()); end
        checks++; if (period_valid !== 0) begin errors++; $display("FAIL bp_drained got=%0b exp=0", period_valid); end
    endtask

    task automatic test_back_to_back();
        enable = 1'b0; toggle_in = 1'b0; period_ready = 1'b1;
        cyc(4);
        enable = 1'b1;
        cyc(2);
        for (int i = 0; i < 12; i++) begin
            flip();
            if (i > 0) sb.push_back(W'(1));
            if (i >= 5) begin
                checks++;
                if (period_valid !== 1) begin errors++; $display("FAIL b2b_valid_cont step=%0d got=%0b exp=1", i, period_valid); end
            end
            cyc(1);
        end
        cyc(4);
        checks++; if (overrun !== 0)      begin errors++; $display("FAIL b2b_overrun got=%0b exp=0", overrun); end
        checks++; if (period_valid !== 0) begin errors++; $display("FAIL b2b_drained got=%0b exp=0", period_valid); end
        checks++; if (sb.size() != 0)     begin errors++; $display("FAIL b2b_pending got=%0d exp=0", sb.size()); end
        enable = 1'b0;
        cyc(2);
    endtask

    task automatic test_timeout();
        enable = 1'b0; toggle_in = 1'b0; period_ready = 1'b1;
        clear = 1'b1; cyc(1); clear = 1'b0;
        cyc(3);
        enable = 1'b1;
        cyc(2);
        flip(); cyc(10);
        flip(); sb.push_back(W'(10)); cyc(3);
        checks++; if (timeout !== 0) begin errors++; $display("FAIL to_at_limit got=%0b exp=0", timeout); end
        cyc(8);
        flip(); cyc(3);
        checks++; if (timeout !== 1) begin errors++; $display("FAIL to_expired got=%0b exp=1", timeout); end
        cyc(4);
        flip(); sb.push_back(W'(7)); cyc(4);
        checks++; if (timeout !== 1)  begin errors++; $display("FAIL to_sticky got=%0b exp=1", timeout); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL to_pending got=%0d exp=0", sb.size()); end
        enable = 1'b0;
        cyc(2);
    endtask

    task automatic test_enable_mid();
        enable = 1'b0; toggle_in = 1'b0; period_ready = 1'b1;
        clear = 1'b1; cyc(1); clear = 1'b0;
        cyc(3);
        enable = 1'b1;
        cyc(2);
        flip(); cyc(5);
        flip(); sb.push_back(W'(5)); cyc(3);
        enable = 1'b0;
        cyc(1);
        toggle_in = 1'b1;
        cyc(5);
        enable = 1'b1;
        cyc(3);
        checks++; if (sb.size() != 0)     begin errors++; $display("FAIL en_pending got=%0d exp=0", sb.size()); end
        checks++; if (period_valid !== 0) begin errors++; $display("FAIL en_false_edge got=%0b exp=0", period_valid); end
        flip(); cyc(7);
        flip(); sb.push_back(W'(7)); cyc(4);
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL en_next_interval got=%0d exp=0", sb.size()); end
        checks++; if (timeout !== 0)  begin errors++; $display("FAIL en_timeout got=%0b exp=0", timeout); end
        enable = 1'b0;
        cyc(2);
    endtask

    task automatic test_reset_mid();
        enable = 1'b0; toggle_in = 1'b1; period_ready = 1'b0;
        cyc(4);
        enable = 1'b1;
        cyc(2);
        flip(); cyc(6);
        flip(); cyc(3);
        flip(); cyc(3);
        checks++; if (overrun !== 1)     begin errors++; $display("FAIL rm_overrun got=%0b exp=1", overrun); end
        checks++; if (period !== W'(6))  begin errors++; $display("FAIL rm_period got=%0d exp=6", period); end
        rst = 1'b1; cyc(1); rst = 1'b0;
        checks++; if (period !== '0)      begin errors++; $display("FAIL rm_period_rst got=%0d exp=0", period); end
        checks++; if (period_valid !== 0) begin errors++; $display("FAIL rm_valid_rst got=%0b exp=0", period_valid); end
        checks++; if (overrun !== 0)      begin errors++; $display("FAIL rm_overrun_rst got=%0b exp=0", overrun); end
        checks++; if (timeout !== 0)      begin errors++; $display("FAIL rm_timeout_rst got=%0b exp=0", timeout); end
        period_ready = 1'b1;
        cyc(2);
        flip(); cyc(8);
        flip(); sb.push_back(W'(8)); cyc(4);
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL rm_next_interval got=%0d exp=0", sb.size()); end
        enable = 1'b0;
        cyc(2);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; clear = 1'b0; toggle_in = 1'b0; period_ready = 1'b0;
        test_reset();
        test_steady();
        test_backpressure();
        test_back_to_back();
        test_timeout();
        test_enable_mid();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
